// File: rtl/adsr_envelope_gen_if.sv
// ---------------------------------------------------------------------------
// adsr_envelope_gen_if
// Bundles the control inputs and envelope outputs of adsr_envelope_gen.
//   sample_en      : one-clk strobe, envelope advances only when high
//   gate           : note gate, high = key held
//   attack_rate    : accumulator step per sample in ATTACK
//   decay_rate     : accumulator step per sample in DECAY
//   release_rate   : accumulator step per sample in RELEASE
//   sustain_level  : sustain amplitude
//   amplitude      : upper AMP_BITS of the accumulator (registered)
//   state          : IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active         : high whenever state != IDLE
// Modports: master drives the controls (testbench / sequencer),
//           slave is the envelope generator.
// ---------------------------------------------------------------------------
interface adsr_envelope_gen_if #(
  parameter int AMP_BITS  = 8,
  parameter int RATE_BITS = 16
);
  logic                 sample_en;
  logic                 gate;
  logic [RATE_BITS-1:0] attack_rate;
  logic [RATE_BITS-1:0] decay_rate;
  logic [RATE_BITS-1:0] release_rate;
  logic [AMP_BITS-1:0]  sustain_level;
  logic [AMP_BITS-1:0]  amplitude;
  logic [2:0]           state;
  logic                 active;

  modport master (
    output sample_en, gate, attack_rate, decay_rate, release_rate, sustain_level,
    input  amplitude, state, active
  );

  modport slave (
    input  sample_en, gate, attack_rate, decay_rate, release_rate, sustain_level,
    output amplitude, state, active
  );
endinterface

// File: rtl/adsr_envelope_gen.sv
// ---------------------------------------------------------------------------
// adsr_envelope_gen
// Linear ADSR envelope generator driven by a sample strobe. An ACC_BITS wide
// accumulator ramps up in ATTACK, down to the sustain level in DECAY, holds in
// SUSTAIN and ramps to zero in RELEASE. The upper AMP_BITS are the amplitude.
// Ports:
//   clk    : design clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adsr_envelope_gen_if.slave (controls in, envelope out)
// Parameters:
//   AMP_BITS     : amplitude width
//   FRAC_BITS    : fractional accumulator bits below the amplitude (>= 1)
//   RATE_BITS    : rate input width, must be <= AMP_BITS+FRAC_BITS
//   RETRIG_RESET : 1 = gate rise restarts attack from 0, 0 = legato
// ---------------------------------------------------------------------------
module adsr_envelope_gen #(
  parameter int AMP_BITS     = 8,
  parameter int FRAC_BITS    = 8,
  parameter int RATE_BITS    = 16,
  parameter bit RETRIG_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adsr_envelope_gen_if.slave   bus
);

  localparam int ACC_BITS = AMP_BITS + FRAC_BITS;
  localparam int PAD_BITS = ACC_BITS + 1 - RATE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [ACC_BITS-1:0] r_acc;
  state_t              r_state;
  logic                r_prev_gate;
  logic                r_active;
  // Cleared by reset, set once gate has been seen low. Keeps a gate that is
  // already high when reset is released from counting as a fresh note.
  logic                r_armed;

  logic [ACC_BITS-1:0] w_acc_next;
  state_t              w_state_next;
  logic                w_rise;
  logic [ACC_BITS:0]   w_att_sum;
  logic [ACC_BITS:0]   w_dec_diff;
  logic [ACC_BITS:0]   w_rel_diff;
  logic [ACC_BITS-1:0] w_sus_acc;
  logic                w_att_done;
  logic                w_dec_done;
  logic                w_rel_done;

  // One extra MSB on every operation exposes carry (attack) and borrow
  // (decay/release) so no wrapped value can ever be loaded into r_acc.
  assign w_att_sum  = {1'b0, r_acc} + {{PAD_BITS{1'b0}}, bus.attack_rate};
  assign w_dec_diff = {1'b0, r_acc} - {{PAD_BITS{1'b0}}, bus.decay_rate};
  assign w_rel_diff = {1'b0, r_acc} - {{PAD_BITS{1'b0}}, bus.release_rate};
  assign w_sus_acc  = {bus.sustain_level, {FRAC_BITS{1'b0}}};

  assign w_rise = bus.gate & ~r_prev_gate & r_armed;

  // A zero rate finishes its segment immediately rather than stalling forever.
  assign w_att_done = (bus.attack_rate == '0) | w_att_sum[ACC_BITS] |
                      (&w_att_sum[ACC_BITS-1:0]);
  // A full-scale sustain level ends decay on its first sample even when the
  // step is too small to reach below {sustain, zeros}.
  assign w_dec_done = (bus.decay_rate == '0) | w_dec_diff[ACC_BITS] |
                      (w_dec_diff[ACC_BITS-1:0] <= w_sus_acc) |
                      (&bus.sustain_level);
  assign w_rel_done = (bus.release_rate == '0) | w_rel_diff[ACC_BITS] |
                      (w_rel_diff[ACC_BITS-1:0] == '0);

  always_comb begin
    w_acc_next   = r_acc;
    w_state_next = r_state;
    if (w_rise) begin
      // A note-on wins over every other transition in the same sample.
      w_state_next = ST_ATTACK;
      if (RETRIG_RESET) begin
        w_acc_next = '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_acc_next = '0;
        end
        ST_ATTACK: begin
          if (!bus.gate) begin
            w_state_next = ST_RELEASE;
          end else if (w_att_done) begin
            w_acc_next   = '1;
            w_state_next = ST_DECAY;
          end else begin
            w_acc_next = w_att_sum[ACC_BITS-1:0];
          end
        end
        ST_DECAY: begin
          if (!bus.gate) begin
            w_state_next = ST_RELEASE;
          end else if (w_dec_done) begin
            w_acc_next   = w_sus_acc;
            w_state_next = ST_SUSTAIN;
          end else begin
            w_acc_next = w_dec_diff[ACC_BITS-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!bus.gate) begin
            w_state_next = ST_RELEASE;
          end else begin
            // Follows live changes of the sustain level.
            w_acc_next = w_sus_acc;
          end
        end
        ST_RELEASE: begin
          if (w_rel_done) begin
            w_acc_next   = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_acc_next = w_rel_diff[ACC_BITS-1:0];
          end
        end
        default: begin
          w_acc_next   = '0;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_state     <= ST_IDLE;
      r_prev_gate <= 1'b0;
      r_active    <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_armed <= r_armed | ~bus.gate;
      if (bus.sample_en) begin
        r_prev_gate <= bus.gate;
        r_acc       <= w_acc_next;
        r_state     <= w_state_next;
        r_active    <= (w_state_next != ST_IDLE);
      end
    end
  end

  assign bus.amplitude = r_acc[ACC_BITS-1 -: AMP_BITS];
  assign bus.state     = r_state;
  assign bus.active    = r_active;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// ---------------------------------------------------------------------------
// tb_adsr_envelope_gen
// Drives two envelope generators (RETRIG_RESET=1 and =0) from the same
// stimulus and compares them every clock against an integer reference model.
// Directed envelopes come first, followed by randomized gate/rate/strobe
// activity.
// ---------------------------------------------------------------------------
module tb_adsr_envelope_gen;
  localparam int AMP  = 8;
  localparam int FRAC = 8;
  localparam int RATE = 16;
  localparam int FULL = (1 << (AMP + FRAC)) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            s_en   = 1'b0;
  logic            s_gate = 1'b0;
  logic [RATE-1:0] s_ar   = '0;
  logic [RATE-1:0] s_dr   = '0;
  logic [RATE-1:0] s_rr   = '0;
  logic [AMP-1:0]  s_sus  = '0;

  adsr_envelope_gen_if #(.AMP_BITS(AMP), .RATE_BITS(RATE)) bus_r ();
  adsr_envelope_gen_if #(.AMP_BITS(AMP), .RATE_BITS(RATE)) bus_l ();

  assign bus_r.sample_en     = s_en;
  assign bus_r.gate          = s_gate;
  assign bus_r.attack_rate   = s_ar;
  assign bus_r.decay_rate    = s_dr;
  assign bus_r.release_rate  = s_rr;
  assign bus_r.sustain_level = s_sus;
  assign bus_l.sample_en     = s_en;
  assign bus_l.gate          = s_gate;
  assign bus_l.attack_rate   = s_ar;
  assign bus_l.decay_rate    = s_dr;
  assign bus_l.release_rate  = s_rr;
  assign bus_l.sustain_level = s_sus;

  adsr_envelope_gen #(.AMP_BITS(AMP), .FRAC_BITS(FRAC), .RATE_BITS(RATE),
                      .RETRIG_RESET(1'b1)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .bus(bus_r)
  );
  adsr_envelope_gen #(.AMP_BITS(AMP), .FRAC_BITS(FRAC), .RATE_BITS(RATE),
                      .RETRIG_RESET(1'b0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, index 0 = retrigger-reset, index 1 = legato.
  // States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_acc[2];
  int m_st[2];
  bit m_prev[2];
  bit m_seen_low[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_st[i] = 0;
      m_prev[i] = 0;
      m_seen_low[i] = 0;
    end
  endfunction

  function automatic void model_clk();
    int nxt;
    int tgt;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_st[i] = 0; m_prev[i] = 0; m_seen_low[i] = 0;
        continue;
      end
      if (s_en) begin
        tgt = int'(s_sus) << FRAC;
        if (s_gate && !m_prev[i] && m_seen_low[i]) begin
          m_st[i] = 1;
          if (i == 0) m_acc[i] = 0;
        end else begin
          case (m_st[i])
            0: m_acc[i] = 0;
            1: if (!s_gate) m_st[i] = 4;
               else begin
                 nxt = m_acc[i] + int'(s_ar);
                 if (s_ar == 0 || nxt >= FULL) begin m_acc[i] = FULL; m_st[i] = 2; end
                 else m_acc[i] = nxt;
               end
            2: if (!s_gate) m_st[i] = 4;
               else begin
                 nxt = m_acc[i] - int'(s_dr);
                 if (s_dr == 0 || s_sus == 8'hFF || nxt <= tgt) begin m_acc[i] = tgt; m_st[i] = 3; end
                 else m_acc[i] = nxt;
               end
            3: if (!s_gate) m_st[i] = 4;
               else m_acc[i] = tgt;
            default: begin
              nxt = m_acc[i] - int'(s_rr);
              if (s_rr == 0 || nxt <= 0) begin m_acc[i] = 0; m_st[i] = 0; end
              else m_acc[i] = nxt;
            end
          endcase
        end
        m_prev[i] = s_gate;
      end
      if (!s_gate) m_seen_low[i] = 1;
    end
  endfunction

  task automatic compare_all();
    check("amp_r",    32'(bus_r.amplitude), 32'(m_acc[0] >> FRAC));
    check("state_r",  32'(bus_r.state),     32'(m_st[0]));
    check("active_r", 32'(bus_r.active),    32'(m_st[0] != 0));
    check("amp_l",    32'(bus_l.amplitude), 32'(m_acc[1] >> FRAC));
    check("state_l",  32'(bus_l.state),     32'(m_st[1]));
    check("active_l", 32'(bus_l.active),    32'(m_st[1] != 0));
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
    compare_all();
  endtask

  // n sample strobes, one every 4 clocks.
  task automatic sample(input int n);
    repeat (n) begin
      s_en = 1'b1;
      cyc();
      s_en = 1'b0;
      repeat (3) cyc();
    end
  endtask

  function automatic logic [RATE-1:0] pick_rate();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return RATE'($urandom_range(16'hF000, 16'hFFFF));
      default: return RATE'($urandom_range(1, 16'h1800));
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (3) cyc();
    check("reset_amp", 32'(bus_r.amplitude), 32'h0);
    rst_n = 1'b1;

    // Attack / decay / sustain / release at the documented rates.
    s_ar = 16'h1000; s_dr = 16'h0800; s_rr = 16'h0100; s_sus = 8'h80;
    sample(2);
    s_gate = 1'b1;
    $display("note on  attack=%h decay=%h release=%h sustain=%h", s_ar, s_dr, s_rr, s_sus);
    sample(2);
    check("attack_first_amp", 32'(bus_r.amplitude), 32'h10);
    sample(15);
    check("attack_peak_amp", 32'(bus_r.amplitude), 32'hFF);
    check("attack_peak_state", 32'(bus_r.state), 32'd2);
    sample(16);
    check("sustain_amp", 32'(bus_r.amplitude), 32'h80);
    check("sustain_state", 32'(bus_r.state), 32'd3);
    s_sus = 8'h40;
    sample(1);
    check("sustain_track", 32'(bus_r.amplitude), 32'h40);
    s_sus = 8'h80;
    sample(1);
    s_gate = 1'b0;
    $display("note off release=%h", s_rr);
    sample(1);
    check("release_entry", 32'(bus_r.state), 32'd4);
    sample(127);
    check("release_not_done", 32'(bus_r.active), 32'd1);
    sample(1);
    check("release_idle_state", 32'(bus_r.state), 32'd0);
    check("release_idle_active", 32'(bus_r.active), 32'd0);

    // Retrigger from release at amplitude 0x40.
    s_gate = 1'b1;
    $display("note on  retrigger setup");
    sample(33);
    s_gate = 1'b0;
    sample(65);
    check("retrig_pre_amp", 32'(bus_l.amplitude), 32'h40);
    s_gate = 1'b1;
    $display("note on  retrigger during release");
    sample(2);
    check("retrig_reset_amp", 32'(bus_r.amplitude), 32'h10);
    check("retrig_legato_amp", 32'(bus_l.amplitude), 32'h50);

    // All rates zero, and gate toggling without a strobe.
    s_ar = '0; s_dr = '0; s_rr = '0; s_gate = 1'b0;
    sample(2);
    s_gate = 1'b1;
    $display("note on  all rates zero");
    sample(2);
    check("zero_attack_amp", 32'(bus_r.amplitude), 32'hFF);
    sample(1);
    check("zero_decay_state", 32'(bus_r.state), 32'd3);
    s_gate = 1'b0; repeat (2) cyc();
    s_gate = 1'b1; cyc();
    check("no_strobe_state", 32'(bus_r.state), 32'd3);
    sample(1);
    check("no_strobe_hold", 32'(bus_r.state), 32'd3);

    // Asynchronous reset mid-attack, gate still high afterwards.
    s_ar = 16'h1000; s_gate = 1'b0;
    sample(2);
    s_gate = 1'b1;
    $display("note on  reset mid-attack");
    sample(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_amp", 32'(bus_r.amplitude), 32'h0);
    check("async_rst_state", 32'(bus_r.state), 32'd0);
    check("async_rst_active", 32'(bus_l.active), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    sample(3);
    check("post_rst_idle", 32'(bus_r.state), 32'd0);
    s_gate = 1'b0;
    sample(1);
    s_gate = 1'b1;
    sample(2);
    check("post_rst_attack", 32'(bus_r.state), 32'd1);

    // Randomized activity.
    for (int c = 0; c < 6000; c++) begin
      s_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) begin
        s_gate = ~s_gate;
        $display("note %s cycle=%0d a=%h d=%h r=%h s=%h", s_gate ? "on " : "off",
                 c, s_ar, s_dr, s_rr, s_sus);
      end
      if ($urandom_range(0, 149) == 0) begin
        s_ar = pick_rate(); s_dr = pick_rate(); s_rr = pick_rate();
      end
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: s_sus = 8'h00;
          1: s_sus = 8'hFF;
          default: s_sus = AMP'($urandom_range(0, 255));
        endcase
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
